// File: rtl/arbitro_prioridade_n.sv
// -----------------------------------------------------------------------------
// arbitro_prioridade_n
//   Sequential N-way arbiter. It issues a registered one-hot grant and keeps it
//   while the owner holds its request line. The winner is chosen by fixed
//   priority (bit 0 highest) or round-robin from a rotating pointer.
//   Optional build macro: ARB_TIMEOUT_EN. When it is defined, an owner that has
//   held the grant for HOLD_MAX cycles while others wait is pre-empted.
//
// Parameters
//   N         number of requesters (2..16)
//   HOLD_MAX  maximum hold time with waiting competitors (timeout build, >= 2)
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req       request lines, bit 0 = highest fixed priority
//   mode      0 = fixed priority, 1 = round-robin
//   grant     registered one-hot grant, zero when idle
//   grant_id  index of the granted requester, zero when idle
//   busy      high whenever grant is non-zero
// -----------------------------------------------------------------------------
module arbitro_prioridade_n #(
  parameter  int N        = 3,
  parameter  int HOLD_MAX = 8,
  localparam int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          busy
);

  if (N < 2 || N > 16 || HOLD_MAX < 2) begin : g_param_check
    $error("arbitro_prioridade_n: N must be 2..16 and HOLD_MAX >= 2");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [IW-1:0]   r_grant_id;
  logic            r_busy;
  logic [IW-1:0]   r_ptr;

  logic [N-1:0]    w_cand;
  logic            w_any;
  logic [IW-1:0]   w_win;
  logic            w_release;
  logic            w_timeout;
  logic            w_take;
  logic            w_drop;

  // First asserted candidate: ascending from 0 in fixed mode, from base with
  // wrap-around in round-robin mode.
  function automatic logic [IW-1:0] f_pick(input logic [N-1:0]  cand,
                                           input logic          rr,
                                           input logic [IW-1:0] base);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = rr ? (int'(base) + k) % N : k;
      if (!found && cand[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return idx;
  endfunction

  // The current owner never competes in the arbitration that replaces it, so
  // a released or pre-empted line only becomes eligible again next decision.
  // In IDLE r_grant is zero and every request competes.
  assign w_cand    = req & ~r_grant;
  assign w_any     = |w_cand;
  assign w_win     = f_pick(w_cand, mode, r_ptr);
  assign w_release = (r_state == S_GRANT) && !(|(req & r_grant));

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX);
  localparam logic [HW-1:0] HCNT_SAT = HW'(HOLD_MAX - 1);

  logic [HW-1:0] r_hcnt;

  assign w_timeout = (r_state == S_GRANT) && (r_hcnt == HCNT_SAT) && w_any;
`else
  assign w_timeout = 1'b0;
`endif

  // New grant: from idle with any request, or on release/pre-emption with a
  // competitor waiting (no idle bubble). Drop to idle on release with nobody
  // else asking.
  assign w_take = ((r_state == S_IDLE) && w_any) ||
                  ((r_state == S_GRANT) && (w_release || w_timeout) && w_any);
  assign w_drop = w_release && !w_any;

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
      r_hcnt     <= '0;
`endif
    end else if (w_take) begin
      r_state    <= S_GRANT;
      r_grant    <= {{(N-1){1'b0}}, 1'b1} << w_win;
      r_grant_id <= w_win;
      r_busy     <= 1'b1;
      // Pointer advances on every new grant, fixed mode included, so a mode
      // switch continues from the last winner.
      r_ptr      <= (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
`ifdef ARB_TIMEOUT_EN
      r_hcnt     <= '0;
`endif
    end else if (w_drop) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hcnt     <= '0;
`endif
    end else if (r_state == S_GRANT) begin
`ifdef ARB_TIMEOUT_EN
      // Saturating hold count; with no competitor the owner keeps the grant.
      if (r_hcnt != HCNT_SAT) r_hcnt <= r_hcnt + 1'b1;
`endif
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_arbitro_prioridade_n.sv
// -----------------------------------------------------------------------------
// tb_arbitro_prioridade_n
//   Scoreboard bench for arbitro_prioridade_n. Stimulus tasks drive inputs on
//   the falling edge and push the grant expected after the next rising edge;
//   a monitor per instance pops and compares 1 time unit after each rising
//   edge. Instances: N=3 with HOLD_MAX=4, and N=8 for the rotation test.
// -----------------------------------------------------------------------------
module tb_arbitro_prioridade_n;

  typedef struct {
    logic [15:0] g;
    string       name;
  } exp_t;

  exp_t q3[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N = 3 instance
  logic       rst3  = 1'b1;
  logic [2:0] req3  = '0;
  logic       mode3 = 1'b0;
  logic [2:0] grant3;
  logic [1:0] gid3;
  logic       busy3;

  arbitro_prioridade_n #(.N(3), .HOLD_MAX(4)) dut3 (
    .clk      (clk),
    .rst      (rst3),
    .req      (req3),
    .mode     (mode3),
    .grant    (grant3),
    .grant_id (gid3),
    .busy     (busy3)
  );

  // N = 8 instance
  logic       rst8  = 1'b1;
  logic [7:0] req8  = '0;
  logic       mode8 = 1'b1;
  logic [7:0] grant8;
  logic [2:0] gid8;
  logic       busy8;

  arbitro_prioridade_n #(.N(8)) dut8 (
    .clk      (clk),
    .rst      (rst8),
    .req      (req8),
    .mode     (mode8),
    .grant    (grant8),
    .grant_id (gid8),
    .busy     (busy8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int idx_of(input logic [15:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic step3(input logic r, input logic [2:0] rq, input logic m,
                       input logic [2:0] eg, input string nm);
    @(negedge clk);
    rst3  = r;
    req3  = rq;
    mode3 = m;
    q3.push_back('{g: 16'(eg), name: nm});
  endtask

  task automatic step8(input logic r, input logic [7:0] rq,
                       input logic [7:0] eg, input string nm);
    @(negedge clk);
    rst8 = r;
    req8 = rq;
    q8.push_back('{g: 16'(eg), name: nm});
  endtask

  // Monitors
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check({e.name, "_grant"}, 32'(grant3), 32'(e.g[2:0]));
        check({e.name, "_id"},    32'(gid3),   32'(idx_of(e.g)));
        check({e.name, "_busy"},  32'(busy3),  32'(|e.g));
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check({e.name, "_grant"},  32'(grant8), 32'(e.g[7:0]));
        check({e.name, "_id"},     32'(gid8),   32'(idx_of(e.g)));
        check({e.name, "_busy"},   32'(busy8),  32'(|e.g));
        check({e.name, "_onehot"}, 32'($countones(grant8) <= 1), 32'd1);
        check({e.name, "_busy_consistent"}, 32'(busy8), 32'(|grant8));
      end
    end
  end

  initial begin
    // Reset with all requests high
    step3(1, 3'b111, 0, 3'b000, "rst_a");
    step3(1, 3'b111, 0, 3'b000, "rst_b");
    step3(0, 3'b111, 0, 3'b001, "first_fixed");
    // Fixed priority and release without bubble
    step3(0, 3'b110, 0, 3'b010, "fixed_110");
    step3(0, 3'b100, 0, 3'b100, "fixed_handoff");
    step3(0, 3'b000, 0, 3'b000, "idle_a");
    // Round-robin rotation 0,1,2,0
    step3(0, 3'b111, 1, 3'b001, "rr_0");
    step3(0, 3'b110, 1, 3'b010, "rr_1");
    step3(0, 3'b101, 1, 3'b100, "rr_2");
    step3(0, 3'b011, 1, 3'b001, "rr_0b");
    step3(0, 3'b000, 1, 3'b000, "idle_b");
    // Pointer follows fixed-mode grants
    step3(0, 3'b100, 0, 3'b100, "fixed_ptr");
    step3(0, 3'b000, 0, 3'b000, "idle_c");
    step3(0, 3'b011, 1, 3'b001, "rr_after_fixed");
    // Reset mid-grant with owner 2
    step3(0, 3'b100, 1, 3'b100, "rr_own2");
    step3(1, 3'b100, 1, 3'b000, "rst_mid");
    step3(0, 3'b101, 1, 3'b001, "post_rst");
    step3(0, 3'b001, 1, 3'b001, "hold");
    step3(0, 3'b000, 1, 3'b000, "idle_d");
    // Reset clears a non-zero pointer
    step3(0, 3'b010, 1, 3'b010, "own1");
    step3(1, 3'b010, 1, 3'b000, "rst_ptr");
    step3(0, 3'b111, 1, 3'b001, "ptr_zero");
    step3(0, 3'b000, 1, 3'b000, "idle_e");
    // Hold-time behaviour: req[0] and req[2] raised together in fixed mode
    step3(0, 3'b101, 0, 3'b001, "to_e1");
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) step3(0, 3'b101, 0, 3'b001, "to_hold0");
    step3(0, 3'b101, 0, 3'b100, "to_preempt");
    for (int i = 0; i < 3; i++) step3(0, 3'b101, 0, 3'b100, "to_hold2");
    step3(0, 3'b101, 0, 3'b001, "to_recompete");
    for (int i = 0; i < 6; i++) step3(0, 3'b001, 0, 3'b001, "to_sat");
    step3(0, 3'b101, 0, 3'b100, "to_sat_fire");
`else
    for (int i = 0; i < 55; i++) step3(0, 3'b101, 0, 3'b001, "nto_hold");
    for (int i = 0; i < 6; i++) step3(0, 3'b001, 0, 3'b001, "nto_alone");
    step3(0, 3'b101, 0, 3'b001, "nto_keep");
`endif
    step3(0, 3'b000, 0, 3'b000, "idle_f");

    // N = 8 round-robin with one-cycle releases
    step8(1, 8'h00, 8'h00, "n8_rst");
    step8(0, 8'hff, 8'h01, "n8_first");
    for (int k = 1; k <= 16; k++)
      step8(0, 8'hff & ~(8'h01 << ((k - 1) % 8)), 8'h01 << (k % 8), "n8_rot");
    step8(0, 8'h00, 8'h00, "n8_idle");

    repeat (3) @(posedge clk);
    #2;
    check("queues_drained", 32'(q3.size() + q8.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arbitro_prioridade_n.md
# arbitro_prioridade_n

- Sequential, parametrised arbiter; successor to the three-input combinational priority queue (TV/PC/Alexa).
- Grants one of `N` requesters a registered one-hot grant and holds it while the requester keeps asking.
- Supports fixed-priority and round-robin modes, with optional forced hand-off after a maximum hold time.
- Sits between device request lines and the shared-resource controller.

## Interface
- `N`, 3: number of requesters, 2..16.
- `HOLD_MAX`, 8: maximum consecutive cycles one grant is held when others are waiting (timeout build only), ≥2.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N: request lines; bit 0 highest fixed priority.
- `mode`  in  1: 0 = fixed priority, 1 = round-robin; sampled at each arbitration decision.
- `grant`  out  N: registered one-hot grant, all-zero when idle.
- `grant_id`  out  $clog2(N): index of granted requester; 0 when idle.
- `busy`  out  1: high whenever `grant` is non-zero.

## Operation
- States: IDLE (no grant), GRANT (owner `g` holds resource).
- IDLE → GRANT when `req != 0`; the winner is chosen by the current mode.
- GRANT → GRANT, same owner, while `req[g]` = 1 and no timeout fires.
- GRANT, `req[g]` = 0 (release):
  - If other requests are pending, arbitrate immediately and grant the new winner on the same edge (no idle bubble).
  - Otherwise return to IDLE.
- Fixed mode: the lowest asserted index wins.
- Round-robin mode:
  - Search starts at `ptr`, wraps N-1 → 0, and the first asserted index wins.
  - On every new grant to `i`, `ptr` ← (i+1) mod N.
  - `ptr` also updates during fixed-mode grants, so switching modes needs no reinitialisation.
- Hold counter `hcnt`:
  - Cleared on every new grant.
  - Increments each GRANT cycle and saturates at HOLD_MAX-1.
- Reset values: `grant` = 0, `grant_id` = 0, `busy` = 0, `ptr` = 0, `hcnt` = 0, state IDLE.
- Reset asserted mid-grant drops the grant on that edge; nothing is preserved.
- Simultaneous release and new requests: the released line is excluded from that arbitration, even if `req[g]` returns high the next cycle.
- A request that drops before being granted is forgotten; there is no latching of requests.

## Timing
- Request → grant latency: 1 cycle. `req` is sampled at edge k and `grant` is valid after edge k.
- Release → re-grant latency: 1 cycle. `req[g]` is low at edge k; the new grant (or idle) is valid after edge k.
- `grant`, `grant_id` and `busy` are all registered and change only on the same edge.
- Outputs are always mutually consistent: `busy` = |`grant`, and `grant_id` = index of `grant`.
- Timeout (macro defined):
  - Fires at the edge where `hcnt` = HOLD_MAX-1 and some `req[j]` = 1 with j ≠ g.
  - Grant moves to the winner among requesters other than `g`, by the current mode.
  - The pre-empted owner must re-compete and is eligible again from the next arbitration.
  - With no competitor, the owner keeps the grant indefinitely and `hcnt` stays saturated.
- Maximum wait in round-robin with timeout: (N-1)·HOLD_MAX cycles.

## Configuration
- `ARB_TIMEOUT_EN` defined: hold counter and pre-emption logic are present, as described above.
- Not defined:
  - No counter is built.
  - Owner holds the grant until it drops `req[g]`.
  - `HOLD_MAX` is ignored.
  - All other behaviour is identical.

## Test plan
- Reset and idle: `rst`=1 for 2 cycles with `req`=3'b111 → `grant`=0, `busy`=0. After `rst`=0, fixed mode → `grant`=3'b001 one cycle later.
- Fixed priority: `req`=3'b110 → `grant`=3'b010, `grant_id`=1. Drop `req[1]` → next cycle `grant`=3'b100 with no idle cycle.
- Round-robin rotation: `mode`=1, `req`=3'b111, each owner drops `req` for one cycle after being granted → grant sequence 0,1,2,0. Hold `req` constant at 3'b111 with owners pulsing low → same fairness.
- Timeout (`ARB_TIMEOUT_EN`, HOLD_MAX=4): `req[0]` held high, `req[2]` raised → `grant[0]` lasts exactly 4 cycles, then `grant`=3'b100. Same stimulus without the macro → `grant[0]` is held for 50+ cycles.
- Reset mid-grant: grant owned by index 2 in round-robin, `rst` pulsed → `grant`=0 and `ptr`=0. With `req`=3'b101 afterwards → `grant`=3'b001.
- Parametrisation: N=8, `mode`=1, all `req` high with 1-cycle releases → each index granted once per 8 grants. `grant_id` matches `grant` and one-hot holds on every cycle.
